// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Holds the transmitter state encoding, the word-length encodings, the
// oversample ratios and helpers for parity and the data-bit index limit.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  // Word-length select encodings (LCR-style)
  localparam logic [1:0] Wls5 = 2'b00;
  localparam logic [1:0] Wls6 = 2'b01;
  localparam logic [1:0] Wls7 = 2'b10;
  localparam logic [1:0] Wls8 = 2'b11;

  // Oversample ticks per bit
  localparam logic [4:0] Osr16 = 5'd16;
  localparam logic [4:0] Osr13 = 5'd13;

  // Parity over the data bits selected by wls. eps=1 returns the XOR,
  // eps=0 returns its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wls,
                                      input logic eps);
    logic [7:0] mask;
    mask = 8'hff >> (2'd3 - wls);
    return eps ? ^(data & mask) : ~(^(data & mask));
  endfunction

  // Index of the last data bit: 5 bits -> 4 ... 8 bits -> 7.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
    return {1'b1, wls};
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: optional one-entry holding register (THR) feeding
// a frame shifter that emits start, 5..8 data bits LSB first, optional parity
// and 1 or 2 stop bits, paced by the oversample tick from the baud generator.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   bclk              one-clk-wide oversample tick
//   mode_osl          0 = 16 ticks/bit, 1 = 13 ticks/bit
//   wls, stb, pen, eps  word length, stop bits, parity enable, parity sense
//   brk               force the line low (break)
//   tx_data, tx_valid, tx_ready  byte handshake
//   txd               registered serial output, idle high
//   tx_empty          high when THR and shifter are both empty
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned HOLD_REG = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       bclk,
  input  logic       mode_osl,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       brk,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_empty
);

  tx_state_e  state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [7:0] thr_q, thr_d;
  logic       thr_full_q, thr_full_d;
  logic       txd_q, txd_d;

  // Frame configuration, frozen when a frame starts
  logic [1:0] f_wls_q, f_wls_d;
  logic       f_stb_q, f_stb_d;
  logic       f_pen_q, f_pen_d;
  logic       f_eps_q, f_eps_d;
  logic       f_osl_q, f_osl_d;

  logic [4:0] osr;
  logic [5:0] stop_len;
  logic       bit_last;
  logic       stop_last;
  logic       accept;
  logic       load;

  assign osr       = f_osl_q ? Osr13 : Osr16;
  assign stop_len  = f_stb_q ? {osr, 1'b0} : {1'b0, osr};
  assign bit_last  = (cnt_q == osr - 5'd1);
  assign stop_last = ({1'b0, cnt_q} == stop_len - 6'd1);

  // Without a THR the same register still buffers the byte between the
  // handshake and the next tick, but it is only writable while idle.
  assign tx_ready = (HOLD_REG != 0) ? !thr_full_q : (state_q == StIdle) && !thr_full_q;
  assign accept   = tx_valid && tx_ready;
  assign tx_empty = (state_q == StIdle) && !thr_full_q;
  assign txd      = txd_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    f_wls_d    = f_wls_q;
    f_stb_d    = f_stb_q;
    f_pen_d    = f_pen_q;
    f_eps_d    = f_eps_q;
    f_osl_d    = f_osl_q;
    load       = 1'b0;

    if (bclk) begin
      case (state_q)
        StIdle: begin
          if (thr_full_q) load = 1'b1;
        end
        StStart: begin
          if (bit_last) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = StData;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        StData: begin
          if (bit_last) begin
            cnt_d   = '0;
            shift_d = {1'b0, shift_q[7:1]};
            if (bit_q == last_bit_idx(f_wls_q)) begin
              state_d = f_pen_q ? StParity : StStop;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        StParity: begin
          if (bit_last) begin
            cnt_d   = '0;
            state_d = StStop;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        StStop: begin
          if (stop_last) begin
            cnt_d = '0;
            // A pending byte starts immediately: no idle gap between frames
            if (thr_full_q) load = 1'b1;
            else            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    if (load) begin
      state_d    = StStart;
      cnt_d      = '0;
      bit_d      = '0;
      shift_d    = thr_q;
      par_d      = parity_bit(thr_q, wls, eps);
      thr_full_d = 1'b0;
      f_wls_d    = wls;
      f_stb_d    = stb;
      f_pen_d    = pen;
      f_eps_d    = eps;
      f_osl_d    = mode_osl;
    end

    // A byte accepted on the load cycle stays in the THR
    if (accept) begin
      thr_d      = tx_data;
      thr_full_d = 1'b1;
    end

    // Line level follows the next state so txd is a clean register output
    case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
      StParity: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
    if (brk) txd_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      thr_q      <= '0;
      thr_full_q <= 1'b0;
      txd_q      <= 1'b1;
      f_wls_q    <= Wls8;
      f_stb_q    <= 1'b0;
      f_pen_q    <= 1'b0;
      f_eps_q    <= 1'b0;
      f_osl_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      thr_q      <= thr_d;
      thr_full_q <= thr_full_d;
      txd_q      <= txd_d;
      f_wls_q    <= f_wls_d;
      f_stb_q    <= f_stb_d;
      f_pen_q    <= f_pen_d;
      f_eps_q    <= f_eps_d;
      f_osl_q    <= f_osl_d;
    end
  end

endmodule
